mem_port_arbiter: RTL and testbench

- Shares the single-port program/data RAM between the instruction-fetch stage (IF) and the memory stage, which is driven by the EX/MEM pipeline register (read/write strobes, address, write data).
- Issues one RAM access at a time, waits out the RAM read latency, and returns read data.
- Generates stall_if / stall_mem so the pipeline freezes while a stage waits for the port.
- Data accesses take priority, with an anti-starvation limit for IF.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port program/data RAM between the instruction-fetch stage
// (IF) and the memory stage (EX/MEM). One RAM access is issued at a time. Reads
// wait out the RAM latency and return data with a one-cycle rvalid pulse.
// Data accesses have priority. IF wins once STARVE_MAX consecutive data grants
// have been issued while it was waiting.
//
// Optional feature: define ARB_PERF_CNT_EN to add saturating 16-bit counters of
// cycles with stall_if / stall_mem high (ports perf_if_stall, perf_mem_stall).
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   if_req/if_addr       fetch read request (held until if_rvalid) and address
//   if_gnt               fetch granted this cycle
//   if_rdata/if_rvalid   fetched word, valid pulse
//   d_read/d_write       data read / write request from EX/MEM
//   d_addr/d_wdata       data address / write data
//   d_gnt                data access granted this cycle
//   d_rdata/d_rvalid     loaded word, valid pulse
//   mem_addr/mem_wdata   RAM address / write data (hold last value when idle)
//   mem_re/mem_we        RAM read / write strobes
//   mem_rdata            RAM read data, valid MEM_LAT cycles after mem_re
//   stall_if/stall_mem   pipeline hold signals
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_rvalid,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
`ifdef ARB_PERF_CNT_EN
    output logic          stall_mem,
    output logic [15:0]   perf_if_stall,
    output logic [15:0]   perf_mem_stall
`else
    output logic          stall_mem
`endif
);

    localparam int unsigned LW = $clog2(MEM_LAT + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e        state_q;
    logic [LW-1:0] lat_cnt_q;
    logic [SW-1:0] starve_cnt_q;
    logic          owner_d_q;  // outstanding read belongs to the data port
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_rvalid_q;
    logic          d_rvalid_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic d_req;
    logic if_elig;
    logic d_elig;
    logic starve_sat;
    logic if_win;
    logic d_win;
    logic rd_grant;

    // Arbitration. A requester sitting in its own rvalid cycle is ineligible so
    // the request still held by the just-released stage is not granted again.
    always_comb begin
        d_req      = d_read | d_write;
        if_elig    = if_req & ~if_rvalid_q;
        d_elig     = d_req & ~d_rvalid_q;
        starve_sat = (starve_cnt_q == SW'(STARVE_MAX));
        if_win     = (state_q == StIdle) & if_elig & (~d_elig | starve_sat);
        d_win      = (state_q == StIdle) & d_elig & ~if_win;
        // d_read together with d_write is treated as a write
        rd_grant   = if_win | (d_win & ~d_write);
    end

    // RAM address/data follow the winner, otherwise hold the last value.
    always_comb begin
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (if_win) begin
            mem_addr = if_addr;
        end else if (d_win) begin
            mem_addr = d_addr;
            if (d_write) begin
                mem_wdata = d_wdata;
            end
        end
    end

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign mem_re    = rd_grant;
    assign mem_we    = d_win & d_write;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign stall_if  = if_req & ~if_rvalid_q;
    assign stall_mem = (d_write & ~d_win) | (d_read & ~d_rvalid_q);

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_if_stall_q;
    logic [15:0] perf_mem_stall_q;

    assign perf_if_stall  = perf_if_stall_q;
    assign perf_mem_stall = perf_mem_stall_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            owner_d_q    <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef ARB_PERF_CNT_EN
            perf_if_stall_q  <= '0;
            perf_mem_stall_q <= '0;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;

            unique case (state_q)
                StIdle: begin
                    // writes complete in their grant cycle; only reads wait
                    if (rd_grant) begin
                        state_q   <= StWait;
                        lat_cnt_q <= LW'(MEM_LAT);
                        owner_d_q <= d_win;
                    end
                end
                StWait: begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                    if (lat_cnt_q == LW'(1)) begin
                        state_q <= StIdle;
                        if (owner_d_q) begin
                            d_rdata_q  <= mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // counts data grants that went ahead of a waiting fetch
            if (!if_req || if_win) begin
                starve_cnt_q <= '0;
            end else if (d_win && !starve_sat) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end

`ifdef ARB_PERF_CNT_EN
            if (stall_if && (perf_if_stall_q != 16'hFFFF)) begin
                perf_if_stall_q <= perf_if_stall_q + 16'd1;
            end
            if (stall_mem && (perf_mem_stall_q != 16'hFFFF)) begin
                perf_mem_stall_q <= perf_mem_stall_q + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with default parameters
// (AW=DW=16, MEM_LAT=1, STARVE_MAX=4).
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]   perf_if_stall;
    logic [15:0]   perf_mem_stall;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
`ifdef ARB_PERF_CNT_EN
        .perf_if_stall  (perf_if_stall),
        .perf_mem_stall (perf_mem_stall),
`endif
        .stall_mem (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with one-cycle read latency and fixed contents.
    logic [AW-1:0] rd_addr_q;
    always @(posedge clk) begin
        if (mem_re) rd_addr_q <= mem_addr;
    end
    always_comb begin
        case (rd_addr_q)
            16'h0040: mem_rdata = 16'hBEEF;
            16'h0080: mem_rdata = 16'hCAFE;
            16'h0002: mem_rdata = 16'h5A5A;
            default:  mem_rdata = rd_addr_q ^ 16'hA5A5;
        endcase
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;

        // ---------------- reset state
        next_cycle; next_cycle;
        #1;
        chk1 ("rst_if_rvalid", if_rvalid, 1'b0);
        chk1 ("rst_d_rvalid", d_rvalid, 1'b0);
        chk16("rst_if_rdata", if_rdata, 16'h0000);
        chk16("rst_d_rdata", d_rdata, 16'h0000);
        chk1 ("rst_mem_re", mem_re, 1'b0);
        chk1 ("rst_mem_we", mem_we, 1'b0);
        chk1 ("rst_stall_if", stall_if, 1'b0);
        chk1 ("rst_stall_mem", stall_mem, 1'b0);
        rst = 1'b0;

        // ---------------- data read
        next_cycle; d_read = 1'b1; d_addr = 16'h0040; #1;
        chk1 ("rd_t_d_gnt", d_gnt, 1'b1);
        chk1 ("rd_t_mem_re", mem_re, 1'b1);
        chk16("rd_t_mem_addr", mem_addr, 16'h0040);
        chk1 ("rd_t_stall_mem", stall_mem, 1'b1);
        chk1 ("rd_t_if_gnt", if_gnt, 1'b0);
        next_cycle; #1;
        chk1 ("rd_t1_d_gnt", d_gnt, 1'b0);
        chk1 ("rd_t1_mem_re", mem_re, 1'b0);
        chk1 ("rd_t1_stall_mem", stall_mem, 1'b1);
        chk1 ("rd_t1_d_rvalid", d_rvalid, 1'b0);
        next_cycle; #1;
        chk1 ("rd_t2_d_rvalid", d_rvalid, 1'b1);
        chk16("rd_t2_d_rdata", d_rdata, 16'hBEEF);
        chk1 ("rd_t2_stall_mem", stall_mem, 1'b0);
        chk1 ("rd_t2_no_regrant", d_gnt, 1'b0);
        chk1 ("rd_t2_mem_re", mem_re, 1'b0);
        next_cycle; d_read = 1'b0; #1;
        chk1 ("rd_t3_d_rvalid", d_rvalid, 1'b0);
        chk16("rd_t3_d_rdata_hold", d_rdata, 16'hBEEF);

        // ---------------- write
        next_cycle; d_write = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234; #1;
        chk1 ("wr_mem_we", mem_we, 1'b1);
        chk1 ("wr_mem_re", mem_re, 1'b0);
        chk16("wr_mem_addr", mem_addr, 16'h0010);
        chk16("wr_mem_wdata", mem_wdata, 16'h1234);
        chk1 ("wr_d_gnt", d_gnt, 1'b1);
        chk1 ("wr_stall_mem", stall_mem, 1'b0);
        next_cycle; d_write = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000; #1;
        chk1 ("wr_t1_d_rvalid", d_rvalid, 1'b0);
        chk1 ("wr_t1_mem_we", mem_we, 1'b0);
        chk16("wr_t1_addr_hold", mem_addr, 16'h0010);
        chk16("wr_t1_wdata_hold", mem_wdata, 16'h1234);

        // ---------------- contention
        next_cycle;
        if_req = 1'b1; if_addr = 16'h0002; d_read = 1'b1; d_addr = 16'h0080; #1;
        chk1 ("ct_t_d_gnt", d_gnt, 1'b1);
        chk1 ("ct_t_if_gnt", if_gnt, 1'b0);
        chk16("ct_t_mem_addr", mem_addr, 16'h0080);
        chk1 ("ct_t_stall_if", stall_if, 1'b1);
        chk1 ("ct_t_stall_mem", stall_mem, 1'b1);
        next_cycle; #1;
        chk1 ("ct_t1_if_gnt", if_gnt, 1'b0);
        chk1 ("ct_t1_d_gnt", d_gnt, 1'b0);
        chk1 ("ct_t1_stall_if", stall_if, 1'b1);
        next_cycle; #1;
        chk1 ("ct_t2_d_rvalid", d_rvalid, 1'b1);
        chk16("ct_t2_d_rdata", d_rdata, 16'hCAFE);
        chk1 ("ct_t2_if_gnt", if_gnt, 1'b1);
        chk1 ("ct_t2_d_gnt", d_gnt, 1'b0);
        chk16("ct_t2_mem_addr", mem_addr, 16'h0002);
        chk1 ("ct_t2_mem_re", mem_re, 1'b1);
        chk1 ("ct_t2_stall_mem", stall_mem, 1'b0);
        chk1 ("ct_t2_stall_if", stall_if, 1'b1);
        next_cycle; d_read = 1'b0; #1;
        chk1 ("ct_t3_if_gnt", if_gnt, 1'b0);
        chk1 ("ct_t3_stall_if", stall_if, 1'b1);
        chk1 ("ct_t3_d_rvalid", d_rvalid, 1'b0);
        next_cycle; #1;
        chk1 ("ct_t4_if_rvalid", if_rvalid, 1'b1);
        chk16("ct_t4_if_rdata", if_rdata, 16'h5A5A);
        chk1 ("ct_t4_stall_if", stall_if, 1'b0);
        chk1 ("ct_t4_if_gnt", if_gnt, 1'b0);
        next_cycle; if_req = 1'b0; #1;
        chk1 ("ct_t5_if_rvalid", if_rvalid, 1'b0);
`ifdef ARB_PERF_CNT_EN
        // includes the two data-read stall cycles from the first read
        chk16("perf_if_stall", perf_if_stall, 16'd4);
        chk16("perf_mem_stall", perf_mem_stall, 16'd4);
`endif

        // ---------------- starvation: back-to-back writes with a waiting fetch
        next_cycle;
        if_req = 1'b1; if_addr = 16'h0004;
        d_write = 1'b1; d_addr = 16'h0020; d_wdata = 16'h7777; #1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin next_cycle; #1; end
            chk1 ("sv_d_gnt", d_gnt, 1'b1);
            chk1 ("sv_if_gnt", if_gnt, 1'b0);
            chk1 ("sv_mem_we", mem_we, 1'b1);
        end
        next_cycle; #1;
        chk1 ("sv_s4_if_gnt", if_gnt, 1'b1);
        chk1 ("sv_s4_d_gnt", d_gnt, 1'b0);
        chk1 ("sv_s4_mem_re", mem_re, 1'b1);
        chk1 ("sv_s4_mem_we", mem_we, 1'b0);
        chk1 ("sv_s4_stall_mem", stall_mem, 1'b1);
        next_cycle; #1;
        chk1 ("sv_s5_d_gnt", d_gnt, 1'b0);
        next_cycle; #1;
        chk1 ("sv_s6_if_rvalid", if_rvalid, 1'b1);
        chk16("sv_s6_if_rdata", if_rdata, 16'hA5A1);
        chk1 ("sv_s6_d_gnt", d_gnt, 1'b1);
        chk1 ("sv_s6_if_gnt", if_gnt, 1'b0);
        // if_req low clears the counter; then four more data grants before IF
        next_cycle; if_req = 1'b0; #1;
        chk1 ("sv_s7_d_gnt", d_gnt, 1'b1);
        next_cycle; if_req = 1'b1; if_addr = 16'h0006; #1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin next_cycle; #1; end
            chk1 ("sv2_d_gnt", d_gnt, 1'b1);
            chk1 ("sv2_if_gnt", if_gnt, 1'b0);
        end
        next_cycle; #1;
        chk1 ("sv2_if_gnt_after4", if_gnt, 1'b1);
        next_cycle; #1;
        next_cycle; #1;
        chk1 ("sv2_if_rvalid", if_rvalid, 1'b1);
        chk16("sv2_if_rdata", if_rdata, 16'hA5A3);
        next_cycle;
        if_req = 1'b0; if_addr = '0; d_write = 1'b0; d_addr = '0; d_wdata = '0;

        // ---------------- reset during an outstanding read
        next_cycle; d_read = 1'b1; d_addr = 16'h0040; #1;
        chk1 ("rr_t_d_gnt", d_gnt, 1'b1);
        next_cycle; rst = 1'b1;
        next_cycle; rst = 1'b0; d_read = 1'b0; d_addr = '0; #1;
        chk1 ("rr_t2_d_rvalid", d_rvalid, 1'b0);
        chk16("rr_t2_d_rdata", d_rdata, 16'h0000);
        chk16("rr_t2_if_rdata", if_rdata, 16'h0000);
        chk1 ("rr_t2_if_rvalid", if_rvalid, 1'b0);
        chk16("rr_t2_mem_addr", mem_addr, 16'h0000);
        chk16("rr_t2_mem_wdata", mem_wdata, 16'h0000);
        chk1 ("rr_t2_mem_re", mem_re, 1'b0);
        chk1 ("rr_t2_stall_mem", stall_mem, 1'b0);
`ifdef ARB_PERF_CNT_EN
        chk16("rr_perf_if", perf_if_stall, 16'd0);
        chk16("rr_perf_mem", perf_mem_stall, 16'd0);
`endif
        next_cycle; d_read = 1'b1; d_addr = 16'h0080; #1;
        chk1 ("rr_t3_d_gnt", d_gnt, 1'b1);
        chk1 ("rr_t3_mem_re", mem_re, 1'b1);
        next_cycle; #1;
        next_cycle; #1;
        chk1 ("rr_t5_d_rvalid", d_rvalid, 1'b1);
        chk16("rr_t5_d_rdata", d_rdata, 16'hCAFE);
        next_cycle; d_read = 1'b0;

        next_cycle;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
